// File: rtl/tpum_pkg.sv
// -----------------------------------------------------------------------------
// tpum_pkg
// Shared definitions for the triple-PUM control slice:
//   - tpum_state_e : one-hot sequencer state code (also exported on state_o)
//   - tpum_op_e    : one-hot operation code (GEMM / BNN / PUM)
//   - default xbox address and dimension widths
//   - APB register-map indices used by the register file
//   - is_onehot3   : command legality helper for the mode field
// -----------------------------------------------------------------------------
package tpum_pkg;

    localparam int TPUM_ADDR_W = 14;
    localparam int TPUM_DIM_W  = 15;

    typedef enum logic [6:0] {
        ST_IDLE     = 7'b000_0001,
        ST_LOAD_R2  = 7'b000_0010,
        ST_LOAD_R1  = 7'b000_0100,
        ST_COMPUTE  = 7'b000_1000,
        ST_WAIT_CMP = 7'b001_0000,
        ST_WRITE_RA = 7'b010_0000,
        ST_DONE     = 7'b100_0000
    } tpum_state_e;

    typedef enum logic [2:0] {
        GEMM_OP = 3'b001,
        BNN_OP  = 3'b010,
        PUM_OP  = 3'b100
    } tpum_op_e;

    // APB register-map word indices
    localparam logic [3:0] REG_MODE   = 4'h0;
    localparam logic [3:0] REG_DIM_A  = 4'h1;
    localparam logic [3:0] REG_DIM_B  = 4'h2;
    localparam logic [3:0] REG_BASE_A = 4'h3;
    localparam logic [3:0] REG_BASE_B = 4'h4;
    localparam logic [3:0] REG_BASE_C = 4'h5;
    localparam logic [3:0] REG_START  = 4'h6;
    localparam logic [3:0] REG_STATE  = 4'h7;

    // True when exactly one of the three mode bits is set
    function automatic logic is_onehot3(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
    endfunction

endpackage

// File: rtl/tpum_xbox_req.sv
// -----------------------------------------------------------------------------
// tpum_xbox_req
// Request holder for the xbox port. A one-cycle issue pulse loads a read
// (rd_o, sel_o) or write (wr_o) request with its address; the request is held
// stable until the xbox acknowledges it or the command is aborted.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   abort_i               drop any pending request at the next edge
//   issue_i               load a new request this edge (wins over completion)
//   issue_wr_i            1 = write RA, 0 = read
//   issue_sel_i           read target: 1 = R1, 0 = R2
//   issue_addr_i          request address
//   ack_i                 xbox completes the pending request this cycle
//   rd_o, wr_o, sel_o, addr_o  registered xbox request outputs
//   done_o                pending request completes at this edge
// -----------------------------------------------------------------------------
module tpum_xbox_req #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort_i,
    input  logic              issue_i,
    input  logic              issue_wr_i,
    input  logic              issue_sel_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              ack_i,
    output logic              rd_o,
    output logic              wr_o,
    output logic              sel_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    logic              rd_q;
    logic              wr_q;
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;

    // An abort suppresses completion so the sequencer never advances on it
    assign done_o = (rd_q | wr_q) & ack_i & ~abort_i;

    // Request register: abort clears, issue loads, completion clears, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            sel_q  <= 1'b0;
            addr_q <= {ADDR_W{1'b0}};
        end else if (abort_i) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            sel_q  <= 1'b0;
            addr_q <= {ADDR_W{1'b0}};
        end else if (issue_i) begin
            rd_q   <= ~issue_wr_i;
            wr_q   <= issue_wr_i;
            sel_q  <= issue_sel_i & ~issue_wr_i;
            addr_q <= issue_addr_i;
        end else if (done_o) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            sel_q  <= 1'b0;
            addr_q <= {ADDR_W{1'b0}};
        end
    end

    assign rd_o   = rd_q;
    assign wr_o   = wr_q;
    assign sel_o  = sel_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/tpum_xbox_sequencer.sv
// -----------------------------------------------------------------------------
// tpum_xbox_sequencer
// Control FSM for the triple-PUM datapath. One accepted start produces, for
// each weight row j: load R2 (skipped for PUM), then for each input row i:
// load R1, one compute pass, write RA at base_c + j*NA + i.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, abort                   command pulse (IDLE/DONE only), sync abort
//   mode, dim_a, dim_b             one-hot op, NA input rows, NB weight rows
//   base_a, base_b, base_c         base xbox rows of inputs/weights/results
//   xbox_ack                       xbox completes the pending rd/wr
//   xbox_rd, xbox_wr, xbox_sel     registered request strobes, R1/R2 select
//   xbox_addr                      request address
//   cmp_start, cmp_done            compute launch pulse / completion
//   busy, done, err                status (done/err are levels)
//   state_o                        one-hot state for the monitor register
// -----------------------------------------------------------------------------
module tpum_xbox_sequencer
    import tpum_pkg::*;
#(
    parameter int ADDR_W = TPUM_ADDR_W,
    parameter int DIM_W  = TPUM_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        mode,
    input  logic [DIM_W-1:0]  dim_a,
    input  logic [DIM_W-1:0]  dim_b,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    input  logic              xbox_ack,
    output logic              xbox_rd,
    output logic              xbox_wr,
    output logic              xbox_sel,
    output logic [ADDR_W-1:0] xbox_addr,
    output logic              cmp_start,
    input  logic              cmp_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [6:0]        state_o
);

    localparam logic [DIM_W-1:0]  ONE_D = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    // base + offset, wrapping silently modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [DIM_W-1:0]  off);
        logic [DIM_W+ADDR_W-1:0] sum;
        sum = {{DIM_W{1'b0}}, base} + {{ADDR_W{1'b0}}, off};
        return sum[ADDR_W-1:0];
    endfunction

    tpum_state_e       state_q;
    logic [DIM_W-1:0]  na_q;
    logic [DIM_W-1:0]  nb_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] cptr_q;
    logic [DIM_W-1:0]  i_q;
    logic [DIM_W-1:0]  j_q;
    logic              cmp_start_q;
    logic              done_q;
    logic              err_q;

    logic              is_pum_s;
    logic              legal_s;
    logic              last_i_s;
    logic              last_j_s;
    logic              xfer_done_s;
    logic              issue_s;
    logic              issue_wr_s;
    logic              issue_sel_s;
    logic [ADDR_W-1:0] issue_addr_s;

    assign is_pum_s = (mode == PUM_OP);
    assign legal_s  = is_onehot3(mode) && (dim_a != {DIM_W{1'b0}}) &&
                      (is_pum_s || (dim_b != {DIM_W{1'b0}}));
    assign last_i_s = (i_q == (na_q - ONE_D));
    assign last_j_s = (j_q == (nb_q - ONE_D));

    // Next xbox request, issued on the same edge as the state change that needs it
    always_comb begin
        issue_s      = 1'b0;
        issue_wr_s   = 1'b0;
        issue_sel_s  = 1'b0;
        issue_addr_s = {ADDR_W{1'b0}};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && legal_s) begin
                    issue_s      = 1'b1;
                    issue_sel_s  = is_pum_s;
                    issue_addr_s = is_pum_s ? base_a : base_b;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_LOAD_R2: begin
                if (xfer_done_s) begin
                    issue_s      = 1'b1;
                    issue_sel_s  = 1'b1;
                    issue_addr_s = row_addr(base_a_q, i_q);
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_WAIT_CMP: begin
                if (cmp_done) begin
                    issue_s      = 1'b1;
                    issue_wr_s   = 1'b1;
                    issue_addr_s = cptr_q;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_WRITE_RA: begin
                if (xfer_done_s && !last_i_s) begin
                    issue_s      = 1'b1;
                    issue_sel_s  = 1'b1;
                    issue_addr_s = row_addr(base_a_q, i_q + ONE_D);
                end else if (xfer_done_s && !last_j_s) begin
                    issue_s      = 1'b1;
                    issue_sel_s  = 1'b0;
                    issue_addr_s = row_addr(base_b_q, j_q + ONE_D);
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    tpum_xbox_req #(
        .ADDR_W(ADDR_W)
    ) u_req (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort_i     (abort),
        .issue_i     (issue_s),
        .issue_wr_i  (issue_wr_s),
        .issue_sel_i (issue_sel_s),
        .issue_addr_i(issue_addr_s),
        .ack_i       (xbox_ack),
        .rd_o        (xbox_rd),
        .wr_o        (xbox_wr),
        .sel_o       (xbox_sel),
        .addr_o      (xbox_addr),
        .done_o      (xfer_done_s)
    );

    // Sequencer state, loop counters, command latch and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            na_q        <= {DIM_W{1'b0}};
            nb_q        <= {DIM_W{1'b0}};
            base_a_q    <= {ADDR_W{1'b0}};
            base_b_q    <= {ADDR_W{1'b0}};
            cptr_q      <= {ADDR_W{1'b0}};
            i_q         <= {DIM_W{1'b0}};
            j_q         <= {DIM_W{1'b0}};
            cmp_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (abort) begin
            // abort beats start, ack and cmp_done; counters are left untouched
            state_q     <= ST_IDLE;
            cmp_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    cmp_start_q <= 1'b0;
                    if (start) begin
                        na_q     <= dim_a;
                        // PUM has no weight rows: run the outer loop once
                        nb_q     <= is_pum_s ? ONE_D : dim_b;
                        base_a_q <= base_a;
                        base_b_q <= base_b;
                        cptr_q   <= base_c;
                        i_q      <= {DIM_W{1'b0}};
                        j_q      <= {DIM_W{1'b0}};
                        if (legal_s) begin
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            state_q <= is_pum_s ? ST_LOAD_R1 : ST_LOAD_R2;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_LOAD_R2: begin
                    if (xfer_done_s) begin
                        state_q <= ST_LOAD_R1;
                    end
                end
                ST_LOAD_R1: begin
                    if (xfer_done_s) begin
                        state_q     <= ST_COMPUTE;
                        cmp_start_q <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    cmp_start_q <= 1'b0;
                    state_q     <= ST_WAIT_CMP;
                end
                ST_WAIT_CMP: begin
                    if (cmp_done) begin
                        state_q <= ST_WRITE_RA;
                    end
                end
                ST_WRITE_RA: begin
                    if (xfer_done_s) begin
                        // result pointer walks base_c + j*NA + i without a multiplier
                        cptr_q <= cptr_q + ONE_A;
                        if (!last_i_s) begin
                            i_q     <= i_q + ONE_D;
                            state_q <= ST_LOAD_R1;
                        end else if (!last_j_s) begin
                            i_q     <= {DIM_W{1'b0}};
                            j_q     <= j_q + ONE_D;
                            state_q <= ST_LOAD_R2;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    cmp_start_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = done_q;
    assign err       = err_q;
    assign cmp_start = cmp_start_q;
    assign state_o   = state_q;

endmodule
